// File: rtl/shift_exec_pipe.sv
// Two-stage EX pipeline around an external right-only 16-bit shifter.
// Stage 1 decodes and registers shifter operands; stage 2 captures and un-reverses the result.
module shift_exec_pipe #(
  parameter int N = 16,
  parameter int C = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [15:0]  instr,
  input  logic [N-1:0] rs_val,
  input  logic [N-1:0] rt_val,
  output logic [N-1:0] sh_in,
  output logic [C-1:0] sh_cnt,
  output logic         sh_op,
  input  logic [N-1:0] sh_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [2:0]   rd,
  output logic         illegal
);

  typedef enum logic [1:0] {
    K_ROL = 2'b00,
    K_SLL = 2'b01,
    K_ROR = 2'b10,
    K_SRL = 2'b11
  } kind_t;

  function automatic logic [N-1:0] rev(input logic [N-1:0] x);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = x[N-1-i];
    return r;
  endfunction

  logic         v1;
  logic         rev1;
  logic [2:0]   rd1;
  logic         ill1;

  logic         s2_free;
  logic         adv1;
  logic         accept;

  kind_t        kind;
  logic         legal;
  logic [C-1:0] n;
  logic [N-1:0] d_in;
  logic [C-1:0] d_cnt;
  logic         d_op;
  logic         d_rev;
  logic [2:0]   d_rd;

  logic         unused_bits;
  assign unused_bits = ^{instr[10:8], rt_val[N-1:C]};

  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !v1 || s2_free;
  assign adv1     = v1 && s2_free;
  assign accept   = in_valid && in_ready && !flush;

  // Immediate opcodes 101xx share their low two bits with the R-form func encoding.
  always_comb begin
    kind  = K_SRL;
    legal = 1'b0;
    n     = instr[C-1:0];
    d_rd  = instr[7:5];
    case (instr[15:11])
      5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
        kind  = kind_t'(instr[12:11]);
        legal = 1'b1;
      end
      5'b11010: begin
        kind  = kind_t'(instr[1:0]);
        legal = 1'b1;
        n     = rt_val[C-1:0];
        d_rd  = instr[4:2];
      end
      default: legal = 1'b0;
    endcase

    d_in  = '0;
    d_cnt = '0;
    d_op  = 1'b1;
    d_rev = 1'b0;
    if (legal) begin
      case (kind)
        K_SRL: begin d_op = 1'b1; d_cnt = n; d_in = rs_val; end
        K_SLL: begin d_op = 1'b1; d_cnt = n; d_in = rev(rs_val); d_rev = 1'b1; end
        K_ROR: begin d_op = 1'b0; d_cnt = n; d_in = rs_val; end
        default: begin d_op = 1'b0; d_cnt = C'(N - int'(n)); d_in = rs_val; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      sh_in  <= '0;
      sh_cnt <= '0;
      sh_op  <= 1'b0;
      rev1   <= 1'b0;
      rd1    <= '0;
      ill1   <= 1'b0;
    end else if (flush) begin
      v1 <= 1'b0;
    end else if (accept) begin
      v1     <= 1'b1;
      sh_in  <= d_in;
      sh_cnt <= d_cnt;
      sh_op  <= d_op;
      rev1   <= d_rev;
      rd1    <= d_rd;
      ill1   <= !legal;
    end else if (adv1) begin
      v1 <= 1'b0;
    end
  end

  // Stage 2 refills in the same edge it drains, so a full pipe sustains one op per clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      rd        <= '0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (adv1) begin
      out_valid <= 1'b1;
      result    <= ill1 ? '0 : (rev1 ? rev(sh_out) : sh_out);
      rd        <= rd1;
      illegal   <= ill1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_exec_pipe.sv
// Directed self-checking bench for shift_exec_pipe; includes a behavioural model of the right-only shifter.
module tb_shift_exec_pipe;

  localparam int N = 16;
  localparam int C = 4;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  instr;
  logic [N-1:0] rs_val;
  logic [N-1:0] rt_val;
  logic [N-1:0] sh_in;
  logic [C-1:0] sh_cnt;
  logic         sh_op;
  logic [N-1:0] sh_out;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result;
  logic [2:0]   rd;
  logic         illegal;

  int checks;
  int failures;

  logic [15:0] q_instr [4];
  logic [15:0] q_rs    [4];
  logic [15:0] q_exp   [4];
  logic [2:0]  q_rd    [4];

  shift_exec_pipe #(.N(N), .C(C)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
    .sh_in(sh_in), .sh_cnt(sh_cnt), .sh_op(sh_op), .sh_out(sh_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .rd(rd), .illegal(illegal)
  );

  // Shifter model: Op=1 logical right, Op=0 rotate right.
  logic [2*N-1:0] dbl;
  always_comb begin
    dbl    = {sh_in, sh_in} >> sh_cnt;
    sh_out = sh_op ? (sh_in >> sh_cnt) : dbl[N-1:0];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] immOp(input logic [4:0] opc, input logic [2:0] r, input logic [3:0] cnt);
    return {opc, 3'b000, r, 1'b0, cnt};
  endfunction

  function automatic logic [15:0] regOp(input logic [1:0] fn, input logic [2:0] r);
    return {5'b11010, 6'b000000, r, fn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic [15:0] ins, input logic [15:0] rs,
                               input logic [15:0] rt, input logic ordy);
    in_valid  = iv;
    instr     = ins;
    rs_val    = rs;
    rt_val    = rt;
    out_ready = ordy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic runSingle(input string tag, input logic [15:0] ins, input logic [15:0] rs,
                           input logic [15:0] rt, input logic [15:0] expIn, input logic [3:0] expCnt,
                           input logic expOp, input logic [15:0] expRes, input logic [2:0] expRd,
                           input logic expIll);
    applyStimulus(1'b1, ins, rs, rt, 1'b1);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    checkOutput({tag, "_shin"}, 32'(sh_in), 32'(expIn));
    checkOutput({tag, "_cnt"}, 32'(sh_cnt), 32'(expCnt));
    checkOutput({tag, "_op"}, 32'(sh_op), 32'(expOp));
    tick();
    checkOutput({tag, "_vld"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_res"}, 32'(result), 32'(expRes));
    checkOutput({tag, "_rd"}, 32'(rd), 32'(expRd));
    checkOutput({tag, "_ill"}, 32'(illegal), 32'(expIll));
    tick();
    checkOutput({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    tick();
    tick();
    $display("[TB] reset state");
    checkOutput("rst_vld", 32'(out_valid), 32'd0);
    checkOutput("rst_res", 32'(result), 32'd0);
    checkOutput("rst_rd", 32'(rd), 32'd0);
    checkOutput("rst_ill", 32'(illegal), 32'd0);
    checkOutput("rst_shin", 32'(sh_in), 32'd0);
    checkOutput("rst_cnt", 32'(sh_cnt), 32'd0);
    checkOutput("rst_op", 32'(sh_op), 32'd0);
    checkOutput("rst_rdy", 32'(in_ready), 32'd1);
    rst = 1'b0;

    $display("[TB] single ops");
    runSingle("slli", immOp(5'b10101, 3'd5, 4'd4), 16'h0001, 16'h0, 16'h8000, 4'd4, 1'b1, 16'h0010, 3'd5, 1'b0);
    runSingle("rol_r", regOp(2'b00, 3'd3), 16'h8001, 16'h0001, 16'h8001, 4'd15, 1'b0, 16'h0003, 3'd3, 1'b0);
    runSingle("roli0", immOp(5'b10100, 3'd2, 4'd0), 16'h1234, 16'h0, 16'h1234, 4'd0, 1'b0, 16'h1234, 3'd2, 1'b0);
    runSingle("rori", immOp(5'b10110, 3'd1, 4'd1), 16'h0001, 16'h0, 16'h0001, 4'd1, 1'b0, 16'h8000, 3'd1, 1'b0);
    runSingle("srli", immOp(5'b10111, 3'd7, 4'd12), 16'hF000, 16'h0, 16'hF000, 4'd12, 1'b1, 16'h000F, 3'd7, 1'b0);
    runSingle("srl_r", regOp(2'b11, 3'd4), 16'h8000, 16'hFFF3, 16'h8000, 4'd3, 1'b1, 16'h1000, 3'd4, 1'b0);
    runSingle("sll_r", regOp(2'b01, 3'd6), 16'h00F0, 16'h0004, 16'h0F00, 4'd4, 1'b1, 16'h0F00, 3'd6, 1'b0);
    runSingle("ror_r", regOp(2'b10, 3'd0), 16'h000F, 16'h0004, 16'h000F, 4'd4, 1'b0, 16'hF000, 3'd0, 1'b0);
    runSingle("illegal", 16'h00E0, 16'hFFFF, 16'hFFFF, 16'h0000, 4'd0, 1'b1, 16'h0000, 3'd7, 1'b1);

    $display("[TB] back-to-back");
    q_instr[0] = immOp(5'b10111, 3'd1, 4'd1); q_rs[0] = 16'h0100; q_exp[0] = 16'h0080; q_rd[0] = 3'd1;
    q_instr[1] = immOp(5'b10101, 3'd2, 4'd2); q_rs[1] = 16'h0003; q_exp[1] = 16'h000C; q_rd[1] = 3'd2;
    q_instr[2] = immOp(5'b10110, 3'd3, 4'd4); q_rs[2] = 16'h1234; q_exp[2] = 16'h4123; q_rd[2] = 3'd3;
    q_instr[3] = immOp(5'b10100, 3'd4, 4'd4); q_rs[3] = 16'h1234; q_exp[3] = 16'h2341; q_rd[3] = 3'd4;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, q_instr[i], q_rs[i], 16'h0, 1'b1);
      checkOutput("b2b_rdy", 32'(in_ready), 32'd1);
      tick();
      if (i > 0) begin
        checkOutput("b2b_vld", 32'(out_valid), 32'd1);
        checkOutput("b2b_res", 32'(result), 32'(q_exp[i-1]));
        checkOutput("b2b_rd", 32'(rd), 32'(q_rd[i-1]));
      end
    end
    applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    tick();
    checkOutput("b2b_last_vld", 32'(out_valid), 32'd1);
    checkOutput("b2b_last_res", 32'(result), 32'(q_exp[3]));
    tick();
    checkOutput("b2b_idle", 32'(out_valid), 32'd0);

    $display("[TB] backpressure");
    applyStimulus(1'b1, immOp(5'b10111, 3'd1, 4'd4), 16'hABCD, 16'h0, 1'b0);
    checkOutput("bp_rdy1", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b1, immOp(5'b10101, 3'd2, 4'd8), 16'h00AB, 16'h0, 1'b0);
    checkOutput("bp_rdy2", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b1, immOp(5'b10110, 3'd3, 4'd8), 16'h1234, 16'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checkOutput("bp_full_rdy", 32'(in_ready), 32'd0);
      checkOutput("bp_hold_vld", 32'(out_valid), 32'd1);
      checkOutput("bp_hold_res", 32'(result), 32'h0ABC);
      checkOutput("bp_hold_rd", 32'(rd), 32'd1);
      checkOutput("bp_hold_shin", 32'(sh_in), 32'hD500);
      checkOutput("bp_hold_cnt", 32'(sh_cnt), 32'd8);
      tick();
    end
    applyStimulus(1'b1, immOp(5'b10110, 3'd3, 4'd8), 16'h1234, 16'h0, 1'b1);
    checkOutput("bp_rel_rdy", 32'(in_ready), 32'd1);
    checkOutput("bp_rel_res1", 32'(result), 32'h0ABC);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    checkOutput("bp_res2_vld", 32'(out_valid), 32'd1);
    checkOutput("bp_res2", 32'(result), 32'hAB00);
    checkOutput("bp_rd2", 32'(rd), 32'd2);
    tick();
    checkOutput("bp_res3_vld", 32'(out_valid), 32'd1);
    checkOutput("bp_res3", 32'(result), 32'h3412);
    checkOutput("bp_rd3", 32'(rd), 32'd3);
    tick();
    checkOutput("bp_idle", 32'(out_valid), 32'd0);

    $display("[TB] flush");
    applyStimulus(1'b1, immOp(5'b10111, 3'd5, 4'd2), 16'h00F0, 16'h0, 1'b0);
    tick();
    applyStimulus(1'b1, immOp(5'b10111, 3'd6, 4'd3), 16'h0F00, 16'h0, 1'b0);
    tick();
    checkOutput("fl_full", 32'(in_ready), 32'd0);
    flush = 1'b1;
    applyStimulus(1'b1, immOp(5'b10101, 3'd7, 4'd1), 16'h0001, 16'h0, 1'b0);
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    checkOutput("fl_vld", 32'(out_valid), 32'd0);
    checkOutput("fl_rdy", 32'(in_ready), 32'd1);
    tick();
    checkOutput("fl_noaccept", 32'(out_valid), 32'd0);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, immOp(5'b10111, 3'd7, 4'd1), 16'h8000, 16'h0, 1'b0);
    tick();
    applyStimulus(1'b1, immOp(5'b10101, 3'd6, 4'd3), 16'hFFFF, 16'h0, 1'b0);
    tick();
    checkOutput("mr_pre_res", 32'(result), 32'h4000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    checkOutput("mr_vld", 32'(out_valid), 32'd0);
    checkOutput("mr_res", 32'(result), 32'd0);
    checkOutput("mr_rd", 32'(rd), 32'd0);
    checkOutput("mr_ill", 32'(illegal), 32'd0);
    checkOutput("mr_shin", 32'(sh_in), 32'd0);
    checkOutput("mr_cnt", 32'(sh_cnt), 32'd0);
    checkOutput("mr_op", 32'(sh_op), 32'd0);
    tick();
    checkOutput("mr_idle", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
